// File: rtl/snail_scan_ctrl.sv
// Word-to-serial scan controller: shifts a captured word MSB-first through an
// overlapping Mealy pattern detector and returns the per-word match count.
module snail_scan_ctrl #(
  parameter int unsigned     WORD_W  = 16,
  parameter int unsigned     PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1101,
  parameter int unsigned     CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              hit,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned SEEN_W = $clog2(PLEN);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PLEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PLEN-2:0]   hist_q, hist_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_shift;
  logic [PLEN-1:0]   window;

  assign in_shift  = (state_q == SHIFT);
  assign ser_valid = in_shift;
  assign ser_bit   = in_shift & sreg_q[WORD_W-1];
  // Last PLEN-1 bits plus the bit on the wire this cycle.
  assign window    = {hist_q, ser_bit};
  // seen saturates at PLEN-1, so equality is the same as >=.
  assign hit       = in_shift && (seen_q == SEEN_MAX) && (window == PATTERN);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign match_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_data;
          idx_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        hist_d = window[PLEN-2:0];
        seen_d = (seen_q == SEEN_MAX) ? seen_q : seen_q + SEEN_W'(1);
        cnt_d  = cnt_q + CNT_W'(hit);
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_snail_scan_ctrl.sv
// Directed bench for snail_scan_ctrl (WORD_W=16, PATTERN=1101).
module tb_snail_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        ser_bit;
  logic        ser_valid;
  logic        hit;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snail_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .hit       (hit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match_cnt (match_cnt)
  );

  // Presents w for one accept edge, then records hit/ser_valid/ser_bit over the
  // 16 shift cycles. Returns at the negedge of cycle T+17 (first DONE cycle).
  task automatic scan_word(input logic [15:0] w, input logic hold_valid,
                           output logic rdy, output logic [15:0] hits,
                           output logic [15:0] svs, output logic [15:0] bits);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    rdy      = in_ready;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    else in_data = 16'hD000;
    for (int i = 0; i < 16; i++) begin
      hits[i]    = hit;
      svs[i]     = ser_valid;
      bits[15-i] = ser_bit;
      @(negedge clk);
    end
  endtask

  task automatic finish_word();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, ser_valid, hit, busy, out_valid, ser_bit, match_cnt} !== {6'b100000, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b sv=%b hit=%b busy=%b ov=%b sb=%b cnt=%0d, want 1 0 0 0 0 0 0",
               in_ready, ser_valid, hit, busy, out_valid, ser_bit, match_cnt);
    end
    reset = 1'b0;
    // out_ready with nothing to hand over must not disturb IDLE.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_out_ready: got busy=%b rdy=%b ov=%b, want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    logic rdy; logic [15:0] hits, svs, bits;
    scan_word(16'hD000, 1'b0, rdy, hits, svs, bits);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL t1_in_ready: got %b want 1", rdy); end
    n_checks++;
    if (svs !== 16'hFFFF) begin n_fail++; $display("FAIL t1_ser_valid: got %h want ffff", svs); end
    n_checks++;
    if (bits !== 16'hD000) begin n_fail++; $display("FAIL t1_ser_bits: got %h want d000", bits); end
    n_checks++;
    if (hits !== 16'h0008) begin n_fail++; $display("FAIL t1_hits: got %h want 0008", hits); end
    n_checks++;
    if (out_valid !== 1'b1 || match_cnt !== 5'd1) begin
      n_fail++; $display("FAIL t1_result: got ov=%b cnt=%0d want ov=1 cnt=1", out_valid, match_cnt);
    end
    finish_word();
  endtask

  task automatic test_overlap();
    logic rdy; logic [15:0] hits, svs, bits;
    scan_word(16'b1101101101101000, 1'b0, rdy, hits, svs, bits);
    n_checks++;
    if (hits !== 16'h1248) begin n_fail++; $display("FAIL t2_hits: got %h want 1248", hits); end
    n_checks++;
    if (out_valid !== 1'b1 || match_cnt !== 5'd4) begin
      n_fail++; $display("FAIL t2_result: got ov=%b cnt=%0d want ov=1 cnt=4", out_valid, match_cnt);
    end
    finish_word();
  endtask

  task automatic test_no_match();
    logic rdy; logic [15:0] hits, svs, bits;
    logic [15:0] words [4] = '{16'hFFFF, 16'h0000, 16'h0006, 16'h8000};
    for (int k = 0; k < 4; k++) begin
      scan_word(words[k], 1'b0, rdy, hits, svs, bits);
      n_checks++;
      if (hits !== 16'h0000 || match_cnt !== 5'd0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL nomatch_%h: got hits=%h cnt=%0d ov=%b want 0000 0 1",
                 words[k], hits, match_cnt, out_valid);
      end
      finish_word();
    end
  endtask

  task automatic test_backpressure();
    logic rdy; logic [15:0] hits, svs, bits;
    int bad;
    // in_valid stays high with another word: must be ignored outside IDLE.
    scan_word(16'hDDDD, 1'b1, rdy, hits, svs, bits);
    n_checks++;
    if (hits !== 16'h8888) begin n_fail++; $display("FAIL t5_hits: got %h want 8888", hits); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || match_cnt !== 5'd4 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL t5_hold: got %0d bad cycles, last ov=%b cnt=%0d rdy=%b, want 0",
                         bad, out_valid, match_cnt, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t5_release: got busy=%b rdy=%b ov=%b want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Throughput: in_valid held high across two words -> 18 cycles per word.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hD000;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!in_ready && cyc < 40);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (cyc != 18) begin n_fail++; $display("FAIL b2b_period: got %0d want 18", cyc); end
    repeat (17) @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hDDDD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (hit !== 1'b1 || match_cnt !== 5'd1) begin
      n_fail++; $display("FAIL t6_pre: got hit=%b cnt=%0d want 1 1", hit, match_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || match_cnt !== 5'd0
        || ser_valid !== 1'b0) begin
      n_fail++; $display("FAIL t6_abort: got busy=%b rdy=%b ov=%b cnt=%0d sv=%b want 0 1 0 0 0",
                         busy, in_ready, out_valid, match_cnt, ser_valid);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t6_stays_idle: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_no_match();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
